// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter
//   Two-master, one-slave arbiter for the single-outstanding
//   avalid/aready/bvalid register bus. One master owns the slave side from
//   its address phase through its response; ownership then re-arbitrates
//   (round-robin, or m0-first when FIXED_PRIO != 0).
//
// Parameters
//   FIXED_PRIO      0 = round-robin, 1 = m0 wins when both request
//   TIMEOUT_CYCLES  response watchdog limit (1..65535), AXI_ARB_TIMEOUT_EN only
//
// Build option
//   AXI_ARB_TIMEOUT_EN  enables the response watchdog; a timed-out
//                       transaction is answered with bdata 32'hDEADBEEF.
//
// Ports
//   clk, rst                 bus clock, synchronous active-high reset
//   m{0,1}_avalid/aready     master request handshake
//   m{0,1}_awe/aaddr/adata/astrb  master request fields
//   m{0,1}_bvalid/bdata      response to master (bdata broadcast)
//   s_avalid/aready, s_awe/aaddr/adata/astrb  request to slave
//   s_bvalid/bdata           response from slave
//   grant                    current or last granted master index

module axi_bus_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_avalid,
  output logic        m0_aready,
  input  logic        m0_awe,
  input  logic [29:0] m0_aaddr,
  input  logic [31:0] m0_adata,
  input  logic [3:0]  m0_astrb,
  output logic        m0_bvalid,
  output logic [31:0] m0_bdata,

  input  logic        m1_avalid,
  output logic        m1_aready,
  input  logic        m1_awe,
  input  logic [29:0] m1_aaddr,
  input  logic [31:0] m1_adata,
  input  logic [3:0]  m1_astrb,
  output logic        m1_bvalid,
  output logic [31:0] m1_bdata,

  output logic        s_avalid,
  input  logic        s_aready,
  output logic        s_awe,
  output logic [29:0] s_aaddr,
  output logic [31:0] s_adata,
  output logic [3:0]  s_astrb,
  input  logic        s_bvalid,
  input  logic [31:0] s_bdata,

  output logic        grant
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        req_g;      // avalid of the granted master
  logic        aready_g;   // aready routed to the granted master
  logic        resp_v;     // bvalid routed to the granted master
  logic        pick;       // winner if arbitration happens this cycle
  logic [31:0] resp_data;

`ifdef AXI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        resp_tmo;
`endif

  // Request fields always follow the granted master; the slave only
  // looks at them while s_avalid is high.
  always_comb begin
    if (grant_q) begin
      req_g   = m1_avalid;
      s_awe   = m1_awe;
      s_aaddr = m1_aaddr;
      s_adata = m1_adata;
      s_astrb = m1_astrb;
    end else begin
      req_g   = m0_avalid;
      s_awe   = m0_awe;
      s_aaddr = m0_aaddr;
      s_adata = m0_adata;
      s_astrb = m0_astrb;
    end
  end

  always_comb begin
    if (m0_avalid && m1_avalid) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end else begin
      pick = m1_avalid;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    s_avalid = 1'b0;
    aready_g = 1'b0;
    resp_v   = 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
    resp_tmo = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m0_avalid || m1_avalid) begin
          grant_d = pick;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_avalid = req_g;
        aready_g = s_aready;
        if (!req_g) begin
          // Abandoned request: not a completed turn, so last_grant stays.
          state_d = ST_IDLE;
        end else if (s_aready) begin
          if (s_bvalid) begin
            // Zero-wait slave: response completes in the accept cycle.
            resp_v  = 1'b1;
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (s_bvalid) begin
          resp_v  = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          resp_v   = 1'b1;
          resp_tmo = 1'b1;
          last_d   = grant_q;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  // Held at zero outside RESP, which gives the clear-on-entry behaviour.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_RESP) begin
      tmo_cnt_q <= '0;
    end else if (!s_bvalid) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign resp_data = resp_tmo ? 32'hDEADBEEF : s_bdata;
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign resp_data = s_bdata;
`endif

  assign m0_aready = aready_g & ~grant_q;
  assign m1_aready = aready_g &  grant_q;
  assign m0_bvalid = resp_v   & ~grant_q;
  assign m1_bvalid = resp_v   &  grant_q;
  assign m0_bdata  = resp_data;
  assign m1_bdata  = resp_data;
  assign grant     = grant_q;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// tb_axi_bus_arbiter
//   Two arbiter instances (index 0: round-robin, index 1: fixed priority)
//   driven by random masters and a random slave, compared every cycle
//   against a transaction-level model of bus ownership.

module tb_axi_bus_arbiter;

  localparam int unsigned TMO  = 4;
  localparam int unsigned NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        av    [2][2];
  logic        awe   [2][2];
  logic [29:0] aaddr [2][2];
  logic [31:0] adata [2][2];
  logic [3:0]  astrb [2][2];
  logic        ardy  [2][2];
  logic        bv    [2][2];
  logic [31:0] bd    [2][2];

  logic        s_av    [2];
  logic        s_ardy  [2];
  logic        s_awe   [2];
  logic [29:0] s_aaddr [2];
  logic [31:0] s_adata [2];
  logic [3:0]  s_astrb [2];
  logic        s_bv    [2];
  logic [31:0] s_bd    [2];
  logic        gnt_o   [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    axi_bus_arbiter #(
      .FIXED_PRIO    (k),
      .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .m0_avalid(av[k][0]),
      .m0_aready(ardy[k][0]),
      .m0_awe   (awe[k][0]),
      .m0_aaddr (aaddr[k][0]),
      .m0_adata (adata[k][0]),
      .m0_astrb (astrb[k][0]),
      .m0_bvalid(bv[k][0]),
      .m0_bdata (bd[k][0]),
      .m1_avalid(av[k][1]),
      .m1_aready(ardy[k][1]),
      .m1_awe   (awe[k][1]),
      .m1_aaddr (aaddr[k][1]),
      .m1_adata (adata[k][1]),
      .m1_astrb (astrb[k][1]),
      .m1_bvalid(bv[k][1]),
      .m1_bdata (bd[k][1]),
      .s_avalid (s_av[k]),
      .s_aready (s_ardy[k]),
      .s_awe    (s_awe[k]),
      .s_aaddr  (s_aaddr[k]),
      .s_adata  (s_adata[k]),
      .s_astrb  (s_astrb[k]),
      .s_bvalid (s_bv[k]),
      .s_bdata  (s_bd[k]),
      .grant    (gnt_o[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Model: owner = -1 means nobody holds the bus; accepted means the
  // owner's request has been taken and a response is pending.
  int owner    [2];
  bit accepted [2];
  int last     [2];
  int gnt_m    [2];
  int waited   [2];
  int mst      [2][2];   // master driver: 0 free, 1 requesting, 2 awaiting response

  bit          e_sav;
  bit          e_ardy [2];
  bit          e_bv   [2];
  bit          tmo;
  logic [31:0] e_bd;
  int          g;
  int          pick;
  string       p;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k]    = -1;
      accepted[k] = 1'b0;
      last[k]     = 1;
      gnt_m[k]    = 0;
      waited[k]   = 0;
      for (int j = 0; j < 2; j++) mst[k][j] = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        av[k][j] = 1'b0; awe[k][j] = 1'b0; aaddr[k][j] = '0;
        adata[k][j] = '0; astrb[k][j] = '0;
      end
      s_ardy[k] = 1'b0; s_bv[k] = 1'b0; s_bd[k] = '0;
    end
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      p = $sformatf("rst k%0d", k);
      check({p, " s_avalid"},  s_av[k],     0);
      check({p, " grant"},     gnt_o[k],    0);
      check({p, " m0_aready"}, ardy[k][0],  0);
      check({p, " m1_aready"}, ardy[k][1],  0);
      check({p, " m0_bvalid"}, bv[k][0],    0);
      check({p, " m1_bvalid"}, bv[k][1],    0);
    end

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(59) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++) begin
          if (mst[k][j] == 0) begin
            awe[k][j]   = 1'($urandom);
            aaddr[k][j] = 30'($urandom);
            adata[k][j] = $urandom;
            astrb[k][j] = 4'($urandom);
            if ($urandom_range(2) == 0) begin
              mst[k][j] = 1;
              av[k][j]  = 1'b1;
            end else begin
              av[k][j] = 1'b0;
            end
          end else if (mst[k][j] == 1) begin
            if ($urandom_range(15) == 0) begin
              mst[k][j] = 0;
              av[k][j]  = 1'b0;
            end
          end else begin
            av[k][j] = 1'b0;
          end
        end
        s_ardy[k] = 1'($urandom);
        s_bv[k]   = ($urandom_range(2) == 0);
        s_bd[k]   = $urandom;
      end
      #1;

      for (int k = 0; k < 2; k++) begin
        g         = gnt_m[k];
        e_sav     = 1'b0;
        e_ardy[0] = 1'b0; e_ardy[1] = 1'b0;
        e_bv[0]   = 1'b0; e_bv[1]   = 1'b0;
        tmo       = 1'b0;
        if (owner[k] >= 0 && !accepted[k]) begin
          e_sav = av[k][owner[k]];
          e_ardy[owner[k]] = s_ardy[k];
          if (av[k][owner[k]] && s_ardy[k] && s_bv[k]) e_bv[owner[k]] = 1'b1;
        end else if (owner[k] >= 0) begin
          if (s_bv[k]) e_bv[owner[k]] = 1'b1;
`ifdef AXI_ARB_TIMEOUT_EN
          else if (waited[k] == int'(TMO) - 1) begin
            e_bv[owner[k]] = 1'b1;
            tmo = 1'b1;
          end
`endif
        end
        e_bd = tmo ? 32'hDEADBEEF : s_bd[k];

        p = $sformatf("c%0d k%0d", cyc, k);
        check({p, " s_avalid"},  s_av[k],    e_sav);
        check({p, " m0_aready"}, ardy[k][0], e_ardy[0]);
        check({p, " m1_aready"}, ardy[k][1], e_ardy[1]);
        check({p, " m0_bvalid"}, bv[k][0],   e_bv[0]);
        check({p, " m1_bvalid"}, bv[k][1],   e_bv[1]);
        check({p, " m0_bdata"},  bd[k][0],   e_bd);
        check({p, " m1_bdata"},  bd[k][1],   e_bd);
        check({p, " grant"},     gnt_o[k],   g);
        check({p, " s_awe"},     s_awe[k],   awe[k][g]);
        check({p, " s_aaddr"},   s_aaddr[k], aaddr[k][g]);
        check({p, " s_adata"},   s_adata[k], adata[k][g]);
        check({p, " s_astrb"},   s_astrb[k], astrb[k][g]);

        if (!rst) begin
          for (int j = 0; j < 2; j++) begin
            if (mst[k][j] == 1 && e_ardy[j]) mst[k][j] = e_bv[j] ? 0 : 2;
            else if (mst[k][j] == 2 && e_bv[j]) mst[k][j] = 0;
          end
          if (owner[k] < 0) begin
            if (av[k][0] || av[k][1]) begin
              if (av[k][0] && av[k][1]) pick = (k == 1) ? 0 : 1 - last[k];
              else pick = av[k][1] ? 1 : 0;
              owner[k]    = pick;
              gnt_m[k]    = pick;
              accepted[k] = 1'b0;
            end
          end else if (!accepted[k]) begin
            if (!av[k][owner[k]]) begin
              owner[k] = -1;
            end else if (s_ardy[k]) begin
              if (s_bv[k]) begin
                last[k]  = owner[k];
                owner[k] = -1;
              end else begin
                accepted[k] = 1'b1;
                waited[k]   = 0;
              end
            end
          end else begin
            if (e_bv[owner[k]]) begin
              last[k]     = owner[k];
              owner[k]    = -1;
              accepted[k] = 1'b0;
            end else begin
              waited[k]++;
            end
          end
        end
      end
      if (rst) model_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
